inst_fetch_queue: RTL and testbench

//  Instruction prefetch stage upstream of the IF/ID pipeline register.

---
 rtl/inst_fetch_queue_if.sv | 27 ++
 rtl/inst_fetch_queue.sv | 128 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Signal bundle between the instruction prefetch queue, the instruction memory
// port, the redirect source and the decode stage.
interface inst_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_pc4;
  logic [31:0] i_inst;

  // master: the fetch queue itself (bus master towards instruction memory)
  modport master (
    input  redirect, redirect_pc, stall, mem_ack, mem_rdata,
    output mem_req, mem_addr, i_valid, i_pc, i_pc4, i_inst
  );

  // slave: the surrounding pipeline and memory
  modport slave (
    output redirect, redirect_pc, stall, mem_ack, mem_rdata,
    input  mem_req, mem_addr, i_valid, i_pc, i_pc4, i_inst
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: issues PC-sequential fetches, buffers returned words
// in a DEPTH-entry FIFO and presents {pc, pc+4, inst} to decode; redirect flushes.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                  clk,
  input logic                  rst_n,
  inst_fetch_queue_if.master   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t        state_reg;
  logic [31:0]   fetch_pc_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic          mem_req_reg;
  logic [31:0]   mem_addr_reg;
  logic          i_valid_reg;
  logic [31:0]   i_pc_reg;
  logic [31:0]   i_pc4_reg;
  logic [31:0]   i_inst_reg;

  logic [63:0]   fifo_mem [DEPTH];

  logic          pending;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_after_pop;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] wr_ptr_next;
  logic [31:0]   fetch_pc_next;
  logic [63:0]   head_next;

  always_comb begin
    pending         = mem_req_reg & ~bus.mem_ack;
    push            = mem_req_reg & bus.mem_ack & (state_reg == FETCH) & ~bus.redirect;
    pop             = i_valid_reg & ~bus.stall & ~bus.redirect;
    count_after_pop = count_reg - CW'(pop);
    count_next      = count_after_pop + CW'(push);
    rd_ptr_next     = rd_ptr_reg + PW'(pop);
    wr_ptr_next     = wr_ptr_reg + PW'(push);
    fetch_pc_next   = push ? fetch_pc_reg + 32'd4 : fetch_pc_reg;
    if (bus.redirect) begin
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      fetch_pc_next = bus.redirect_pc;
    end
    // An empty queue after the pop means the new head is the word arriving now.
    head_next = (count_after_pop == '0) ? {fetch_pc_reg, bus.mem_rdata}
                                        : fifo_mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {fetch_pc_reg, bus.mem_rdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      i_valid_reg  <= 1'b0;
      i_pc_reg     <= '0;
      i_pc4_reg    <= '0;
      i_inst_reg   <= '0;
    end else begin
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      fetch_pc_reg <= fetch_pc_next;
      i_valid_reg  <= (count_next != '0);
      if (count_next != '0) begin
        i_pc_reg   <= head_next[63:32];
        i_pc4_reg  <= head_next[63:32] + 32'd4;
        i_inst_reg <= head_next[31:0];
      end else begin
        i_pc_reg   <= '0;
        i_pc4_reg  <= '0;
        i_inst_reg <= '0;
      end

      case (state_reg)
        FETCH: begin
          if (bus.redirect && pending) begin
            // Request cannot be withdrawn: keep its address and swallow its data.
            state_reg   <= DISCARD;
            mem_req_reg <= 1'b1;
          end else begin
            mem_req_reg  <= pending | (count_next < FULL_COUNT);
            mem_addr_reg <= fetch_pc_next;
          end
        end
        DISCARD: begin
          if (bus.mem_ack) begin
            state_reg    <= FETCH;
            mem_req_reg  <= (count_next < FULL_COUNT);
            mem_addr_reg <= fetch_pc_next;
          end else begin
            mem_req_reg  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.mem_req  = mem_req_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.i_valid  = i_valid_reg;
  assign bus.i_pc     = i_pc_reg;
  assign bus.i_pc4    = i_pc4_reg;
  assign bus.i_inst   = i_inst_reg;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: stimulus table, corner-case sequences
// and randomized traffic, all compared against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Reference model: FIFO contents, next fetch address, visible request state.
  entry_t      mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_disc;

  typedef struct {
    bit          stall;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch = RESET_PC;
    m_addr  = '0;
    m_req   = 1'b0;
    m_disc  = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc, input bit ak);
    bit     acc;
    bit     still_waiting;
    entry_t e;
    acc           = m_req && ak;
    still_waiting = m_req && !ak;
    if (rd) begin
      mq.delete();
      m_fetch = rpc;
      m_disc  = still_waiting;
    end else begin
      if (mq.size() != 0 && !st) begin
        e = mq.pop_front();
        $display("deliver pc=%h inst=%h", e.pc, e.inst);
      end
      if (acc) begin
        if (m_disc) begin
          m_disc = 1'b0;
        end else begin
          mq.push_back('{pc: m_addr, inst: word_of(m_addr)});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    if (m_disc || still_waiting) begin
      m_req = 1'b1;
    end else begin
      m_req  = (mq.size() < DEPTH);
      m_addr = m_fetch;
    end
  endtask

  task automatic compare_model();
    check("mem_req", 32'(bus.mem_req), 32'(m_req));
    if (m_req) check("mem_addr", bus.mem_addr, m_addr);
    check("i_valid", 32'(bus.i_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("i_pc",   bus.i_pc,   mq[0].pc);
      check("i_pc4",  bus.i_pc4,  mq[0].pc + 32'd4);
      check("i_inst", bus.i_inst, mq[0].inst);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic tick(input bit st, input bit rd, input logic [31:0] rpc, input bit ak);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.mem_ack     = ak;
    bus.mem_rdata   = ak ? word_of(bus.mem_addr) : 32'hDEAD_BEEF;
    model_step(st, rd, rpc, ak);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // Asynchronous reset from mid-cycle; release with a stale ack that must be ignored.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_i_valid", 32'(bus.i_valid), 32'd0);
    check("rst_i_pc",    bus.i_pc,   32'd0);
    check("rst_i_pc4",   bus.i_pc4,  32'd0);
    check("rst_i_inst",  bus.i_inst, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic set_row(input int k, input bit st, input bit rq, input logic [31:0] a,
                         input bit v, input logic [31:0] pc);
    tbl[k] = '{stall: st, exp_req: rq, exp_addr: a, exp_valid: v, exp_pc: pc};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st, rd, ak, pend;
    int          lat;
    logic [31:0] rpc;

    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    pend = 1'b0; lat = 0;

    // Zero-wait streaming, then a 10-cycle stall that fills the queue, then drain.
    set_row(0,  0, 1, 32'h00, 0, 32'h00);
    set_row(1,  0, 1, 32'h04, 1, 32'h00);
    set_row(2,  0, 1, 32'h08, 1, 32'h04);
    set_row(3,  0, 1, 32'h0C, 1, 32'h08);
    set_row(4,  1, 1, 32'h10, 1, 32'h0C);
    set_row(5,  1, 1, 32'h14, 1, 32'h0C);
    set_row(6,  1, 1, 32'h18, 1, 32'h0C);
    for (int k = 7; k <= 13; k++) set_row(k, 1, 0, 32'h0, 1, 32'h0C);
    set_row(14, 0, 0, 32'h00, 1, 32'h0C);
    set_row(15, 0, 1, 32'h1C, 1, 32'h10);
    set_row(16, 0, 1, 32'h20, 1, 32'h14);
    set_row(17, 0, 1, 32'h24, 1, 32'h18);
    set_row(18, 0, 1, 32'h28, 1, 32'h1C);

    do_reset();
    for (int k = 0; k < 19; k++) begin
      check("tbl_req", 32'(bus.mem_req), 32'(tbl[k].exp_req));
      if (tbl[k].exp_req) check("tbl_addr", bus.mem_addr, tbl[k].exp_addr);
      check("tbl_valid", 32'(bus.i_valid), 32'(tbl[k].exp_valid));
      if (tbl[k].exp_valid) begin
        check("tbl_pc",   bus.i_pc,   tbl[k].exp_pc);
        check("tbl_pc4",  bus.i_pc4,  tbl[k].exp_pc + 32'd4);
        check("tbl_inst", bus.i_inst, word_of(tbl[k].exp_pc));
      end
      tick(tbl[k].stall, 1'b0, 32'h0, 1'b1);
    end

    // Redirect while a slow request at 0x8 is outstanding.
    do_reset();
    tick(0, 0, 32'h0, 1);
    tick(0, 0, 32'h0, 1);
    check("t3_addr8", bus.mem_addr, 32'h8);
    tick(0, 0, 32'h0, 0);
    tick(0, 1, 32'h100, 0);
    check("t3_hold_req", 32'(bus.mem_req), 32'd1);
    check("t3_hold_addr", bus.mem_addr, 32'h8);
    tick(0, 0, 32'h0, 0);
    check("t3_hold_addr2", bus.mem_addr, 32'h8);
    tick(0, 0, 32'h0, 1);
    check("t3_new_addr", bus.mem_addr, 32'h100);
    check("t3_empty", 32'(bus.i_valid), 32'd0);
    tick(0, 0, 32'h0, 1);
    check("t3_first_pc", bus.i_pc, 32'h100);

    // Redirect coinciding with an ack while two entries are queued.
    do_reset();
    tick(1, 0, 32'h0, 1);
    tick(1, 0, 32'h0, 1);
    tick(1, 1, 32'h40, 1);
    check("t4_valid", 32'(bus.i_valid), 32'd0);
    check("t4_addr", bus.mem_addr, 32'h40);
    tick(0, 0, 32'h0, 1);
    check("t4_first_pc", bus.i_pc, 32'h40);

    // Two redirects while discarding: only the latest target is fetched.
    do_reset();
    tick(0, 0, 32'h0, 0);
    tick(0, 1, 32'h200, 0);
    tick(0, 1, 32'h300, 0);
    check("t5_held", bus.mem_addr, 32'h0);
    tick(0, 0, 32'h0, 1);
    check("t5_addr", bus.mem_addr, 32'h300);
    tick(0, 0, 32'h0, 1);
    check("t5_pc0", bus.i_pc, 32'h300);
    tick(0, 0, 32'h0, 1);
    check("t5_pc1", bus.i_pc, 32'h304);

    // Full queue, then reset while a request is waiting.
    do_reset();
    for (int k = 0; k < 4; k++) tick(1, 0, 32'h0, 1);
    check("t6_full_req", 32'(bus.mem_req), 32'd0);
    tick(0, 0, 32'h0, 0);
    tick(1, 0, 32'h0, 0);
    bus.mem_ack = 1'b1;
    do_reset();
    check("t6_restart", bus.mem_addr, RESET_PC);
    tick(0, 0, 32'h0, 1);
    check("t6_first_pc", bus.i_pc, RESET_PC);

    // Randomized traffic: variable latency, stalls, redirects (some near the wrap point).
    do_reset();
    pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 99) < 35);
      rd  = ($urandom_range(0, 99) < 6);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2))
                                        : ($urandom & 32'hFFFF_FFFC);
      if (bus.mem_req) begin
        if (!pend) begin
          pend = 1'b1;
          lat  = $urandom_range(0, 3);
        end
        ak = (lat == 0);
        if (ak) pend = 1'b0;
        else    lat--;
      end else begin
        pend = 1'b0;
        ak   = ($urandom_range(0, 9) == 0);
      end
      tick(st, rd, rpc, ak);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
